// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_pkg;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {FETCH, HOLD, KILL} state_t;
endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {instr, pc, full} parking buffer for a response that arrives while decode is stalled.
// Flush wins over load; drain empties the entry once it has been handed to F/D.
module fetch_hold_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         drain,
    input  logic         flush,
    input  logic [W-1:0] load_instr,
    input  logic [W-1:0] load_pc,
    output logic         full,
    output logic [W-1:0] instr,
    output logic [W-1:0] pc
);
    always_ff @(posedge clk) begin
        if (reset) begin
            full  <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (flush || drain) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, imem req/ack handshake, F/D register, stall hold and branch kill.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                      ADDRESS_SIZE = 32,
    parameter logic [ADDRESS_SIZE-1:0] RESET_PC     = ADDRESS_SIZE'(DEFAULT_RESET_PC)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    F_stall,
    input  logic                    F_branch,
    input  logic [ADDRESS_SIZE-1:0] F_branch_target,
    output logic                    imem_req,
    output logic [ADDRESS_SIZE-1:0] imem_addr,
    input  logic                    imem_ack,
    input  logic [ADDRESS_SIZE-1:0] imem_data,
    output logic [ADDRESS_SIZE-1:0] F_instruction,
    output logic [ADDRESS_SIZE-1:0] F_pc,
    output logic                    F_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]             perf_fetched,
    output logic [31:0]             perf_bubbles
`endif
);
    localparam logic [ADDRESS_SIZE-1:0] NOP  = ADDRESS_SIZE'(NOP_INSTR);
    localparam logic [ADDRESS_SIZE-1:0] STEP = ADDRESS_SIZE'(INSTR_BYTES);

    state_t                  state;
    logic [ADDRESS_SIZE-1:0] pc_q;
    logic [ADDRESS_SIZE-1:0] kill_addr_q;
    logic [ADDRESS_SIZE-1:0] target;
    logic [ADDRESS_SIZE-1:0] buf_instr;
    logic [ADDRESS_SIZE-1:0] buf_pc;
    logic                    buf_full;
    logic                    take_branch;
    logic                    buf_load;
    logic                    buf_drain;
    logic                    buf_flush;

    assign target      = F_branch_target & ~ADDRESS_SIZE'(3);
    assign take_branch = F_branch & ~F_stall;
    assign imem_req    = ~reset & (state != HOLD);
    // KILL keeps presenting the abandoned address until memory completes it.
    assign imem_addr   = (state == KILL) ? kill_addr_q : pc_q;
    assign buf_load    = (state == FETCH) & imem_ack & F_stall;
    assign buf_drain   = (state == HOLD) & ~F_stall & ~take_branch;
    assign buf_flush   = (state == HOLD) & take_branch;

    fetch_hold_buf #(.W(ADDRESS_SIZE)) u_hold_buf (
        .clk        (clk),
        .reset      (reset),
        .load       (buf_load),
        .drain      (buf_drain),
        .flush      (buf_flush),
        .load_instr (imem_data),
        .load_pc    (pc_q),
        .full       (buf_full),
        .instr      (buf_instr),
        .pc         (buf_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= FETCH;
            pc_q          <= RESET_PC;
            kill_addr_q   <= '0;
            F_valid       <= 1'b0;
            F_instruction <= NOP;
            F_pc          <= '0;
        end else if (take_branch) begin
            pc_q          <= target;
            F_valid       <= 1'b0;
            F_instruction <= NOP;
            case (state)
                FETCH: if (!imem_ack) begin
                    state       <= KILL;
                    kill_addr_q <= pc_q;
                end
                HOLD:    state <= FETCH;
                KILL:    if (imem_ack) state <= FETCH;
                default: state <= FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack && !F_stall) begin
                        F_valid       <= 1'b1;
                        F_instruction <= imem_data;
                        F_pc          <= pc_q;
                        pc_q          <= pc_q + STEP;
                    end else if (imem_ack) begin
                        state <= HOLD;
                    end else if (!F_stall) begin
                        F_valid       <= 1'b0;
                        F_instruction <= NOP;
                    end
                end
                HOLD: if (!F_stall) begin
                    F_valid       <= buf_full;
                    F_instruction <= buf_instr;
                    F_pc          <= buf_pc;
                    pc_q          <= pc_q + STEP;
                    state         <= FETCH;
                end
                KILL: begin
                    if (imem_ack) state <= FETCH;
                    if (!F_stall) begin
                        F_valid       <= 1'b0;
                        F_instruction <= NOP;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic load_valid;
    logic load_bubble;

    // Every unstalled cycle loads F/D with either a real instruction or a bubble.
    assign load_valid  = ~F_stall & ~take_branch &
                         (((state == FETCH) & imem_ack) | ((state == HOLD) & buf_full));
    assign load_bubble = ~F_stall & ~load_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (load_valid)  perf_fetched <= perf_fetched + 32'd1;
            if (load_bubble) perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench: expected fetch stream is sequential from reset PC or branch target.
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        F_stall = 1'b0;
    logic        F_branch = 1'b0;
    logic [31:0] F_branch_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = '0;
    logic [31:0] F_instruction;
    logic [31:0] F_pc;
    logic        F_valid;

    logic        reset2 = 1'b1;
    logic        stall2 = 1'b0;
    logic        ack2_en = 1'b0;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        ack2;
    logic [31:0] data2;
    logic [31:0] F_instruction2;
    logic [31:0] F_pc2;
    logic        F_valid2;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_bubbles, perf_fetched2, perf_bubbles2;
`endif

    assign ack2  = imem_req2 & ack2_en;
    assign data2 = imem_addr2;

    always #5 clk = ~clk;

    fetch_unit #(.ADDRESS_SIZE(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .reset(reset), .F_stall(F_stall), .F_branch(F_branch),
        .F_branch_target(F_branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .F_instruction(F_instruction),
        .F_pc(F_pc), .F_valid(F_valid)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
    );

    fetch_unit #(.ADDRESS_SIZE(32), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .reset(reset2), .F_stall(stall2), .F_branch(1'b0),
        .F_branch_target(32'h0), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(ack2), .imem_data(data2), .F_instruction(F_instruction2),
        .F_pc(F_pc2), .F_valid(F_valid2)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched2), .perf_bubbles(perf_bubbles2)
`endif
    );

    int n_checks = 0;
    int n_fail = 0;
    int valid_seen = 0;

    task automatic chk(input bit ok, input string name, input logic [95:0] act, input logic [95:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: the delivered stream is strictly sequential from the last restart point.
    logic [31:0] exp_q[$];
    logic [31:0] exp_tail;
    logic [31:0] data_xor = '0;
    logic [31:0] wrap_q[$];

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ data_xor;
    endfunction

    task automatic refill(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
        exp_tail = start + 32'(4 * 63);
    endtask

    bit started = 0;
    bit rec_reset, rec_stall, rec_reset2, rec_stall2;

    always @(posedge clk) begin
        started    = 1;
        rec_reset  = reset;
        rec_stall  = F_stall;
        rec_reset2 = reset2;
        rec_stall2 = stall2;
        if (reset) refill(32'h0);
        else if (F_branch && !F_stall) refill(F_branch_target & ~32'h3);
    end

    logic [64:0] prev_fd;
    always @(negedge clk) begin
        if (started) begin
            if (rec_reset) begin
                chk(F_valid == 1'b0 && F_pc == 32'h0 && F_instruction == NOP, "reset_fd",
                    {F_valid, F_pc, F_instruction}, {1'b0, 32'h0, NOP});
                if (reset) chk(imem_req == 1'b0, "reset_req", imem_req, 0);
            end else if (rec_stall) begin
                chk({F_valid, F_pc, F_instruction} == prev_fd, "stall_hold",
                    {F_valid, F_pc, F_instruction}, prev_fd);
            end else if (F_valid) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "stream_empty", F_pc, 0);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    exp_tail = exp_tail + 32'd4;
                    exp_q.push_back(exp_tail);
                    chk(F_pc == e, "stream_pc", F_pc, e);
                    chk(F_instruction == mem_fn(e), "stream_instr", F_instruction, mem_fn(e));
                    valid_seen++;
                end
            end else begin
                chk(F_instruction == NOP, "bubble_nop", F_instruction, NOP);
            end
            prev_fd = {F_valid, F_pc, F_instruction};

            if (!rec_reset2 && !rec_stall2 && F_valid2) begin
                if (wrap_q.size() == 0) chk(1'b0, "wrap_extra", F_pc2, 0);
                else begin
                    logic [31:0] w;
                    w = wrap_q.pop_front();
                    chk(F_pc2 == w && F_instruction2 == w, "wrap_pc", {F_pc2, F_instruction2}, {w, w});
                end
            end
        end
    end

    // Memory: per-request latency, ack held until sampled, address must stay stable.
    bit          rand_lat = 0;
    logic [31:0] slow_addr = 32'hFFFF_FFFF;
    int          cnt = 0;
    int          cur_lat = 0;
    bit          mem_acked = 0;
    logic [31:0] req_addr = '0;

    always @(negedge clk) begin
        if (reset || !imem_req || mem_acked) cnt = 0;
        mem_acked = 0;
        imem_ack  = 1'b0;
        if (!reset && imem_req) begin
            if (cnt == 0) begin
                req_addr = imem_addr;
                cur_lat  = rand_lat ? int'($urandom_range(0, 2)) : ((imem_addr == slow_addr) ? 2 : 0);
            end else begin
                chk(imem_addr == req_addr, "addr_stable", imem_addr, req_addr);
            end
            if (cnt >= cur_lat) begin
                imem_ack  = 1'b1;
                imem_data = (!rand_lat && imem_addr == 32'h40) ? 32'hDEAD : mem_fn(imem_addr);
                mem_acked = 1;
            end
            cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_addr(input logic [31:0] a, input int budget);
        int n = 0;
        while (!(imem_req && imem_addr == a) && n < budget) begin
            tick();
            n++;
        end
        chk(imem_req && imem_addr == a, "wait_addr", {imem_req, imem_addr}, {1'b1, a});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: same-cycle acks, back-to-back stream
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk(imem_req && imem_addr == 32'h0, "first_req", {imem_req, imem_addr}, {1'b1, 32'h0});
        for (int i = 0; i < 4; i++) begin
            tick();
            chk(F_valid && F_pc == 32'(4 * i), "seq_pc", {F_valid, F_pc}, {1'b1, 32'(4 * i)});
        end

        // 2: two-cycle latency at address 8
        reset = 1'b1;
        slow_addr = 32'h8;
        repeat (2) tick();
        reset = 1'b0;
        wait_addr(32'h8, 10);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk(!F_valid && imem_addr == 32'h8, "slow_wait", {F_valid, imem_addr}, {1'b0, 32'h8});
        end
        tick();
        chk(F_valid && F_pc == 32'h8, "slow_done", {F_valid, F_pc}, {1'b1, 32'h8});

        // 3: stall while ack for 0x10 arrives
        wait_addr(32'h10, 10);
        F_stall = 1'b1;
        tick();
        chk(!imem_req && F_pc == 32'hC, "hold_req", {imem_req, F_pc}, {1'b0, 32'hC});
        repeat (2) tick();
        F_stall = 1'b0;
        tick();
        chk(F_valid && F_pc == 32'h10, "hold_drain", {F_valid, F_pc}, {1'b1, 32'h10});
        chk(imem_req && imem_addr == 32'h14, "after_hold", {imem_req, imem_addr}, {1'b1, 32'h14});

        // 4: branch while 0x40 outstanding
        slow_addr = 32'h40;
        wait_addr(32'h40, 40);
        F_branch = 1'b1;
        F_branch_target = 32'h200;
        tick();
        F_branch = 1'b0;
        chk(imem_req && imem_addr == 32'h40 && !F_valid, "kill_addr",
            {F_valid, imem_req, imem_addr}, {1'b0, 1'b1, 32'h40});
        wait_addr(32'h200, 10);
        tick();
        chk(F_valid && F_pc == 32'h200 && F_instruction == 32'h200, "branch_tgt",
            {F_valid, F_pc, F_instruction}, {1'b1, 32'h200, 32'h200});

        // 5: branch ignored during stall, applied on release
        F_stall = 1'b1;
        F_branch = 1'b1;
        F_branch_target = 32'h300;
        tick();
        chk(!imem_req && imem_addr == 32'h204, "stall_br1", {imem_req, imem_addr}, {1'b0, 32'h204});
        tick();
        chk(imem_addr == 32'h204 && F_pc == 32'h200, "stall_br2", {imem_addr, F_pc}, {32'h204, 32'h200});
        F_stall = 1'b0;
        tick();
        F_branch = 1'b0;
        chk(imem_addr == 32'h300 && !F_valid, "br_release", {F_valid, imem_addr}, {1'b0, 32'h300});
        tick();
        chk(F_valid && F_pc == 32'h300, "br_fetch", {F_valid, F_pc}, {1'b1, 32'h300});

        // Randomized traffic
        reset = 1'b1;
        tick();
        data_xor = $urandom;
        rand_lat = 1;
        reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            F_stall = ($urandom_range(0, 3) == 0);
            F_branch = ($urandom_range(0, 15) == 0);
            F_branch_target = $urandom;
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        F_stall = 1'b0;
        F_branch = 1'b0;
        reset = 1'b0;
        tick();
        chk(valid_seen > 500, "rand_volume", valid_seen, 500);

        // 6: PC wrap and perf counters on the second instance
        reset2 = 1'b0;
        #1;
        chk(imem_req2 && imem_addr2 == 32'hFFFF_FFF8, "wrap_first", {imem_req2, imem_addr2}, {1'b1, 32'hFFFF_FFF8});
        tick();
        chk(!F_valid2, "wrap_bub1", F_valid2, 0);
        tick();
        chk(!F_valid2, "wrap_bub2", F_valid2, 0);
        wrap_q = {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        ack2_en = 1'b1;
        repeat (4) tick();
        ack2_en = 1'b0;
        stall2 = 1'b1;
        chk(F_valid2 && F_pc2 == 32'h4, "wrap_last", {F_valid2, F_pc2}, {1'b1, 32'h4});
        tick();
        chk(wrap_q.size() == 0, "wrap_all", wrap_q.size(), 0);
`ifdef FETCH_PERF_CNT_EN
        chk(perf_fetched2 == 32'd4 && perf_bubbles2 == 32'd2, "perf_cnt",
            {perf_fetched2, perf_bubbles2}, {32'd4, 32'd2});
        reset2 = 1'b1;
        tick();
        chk(perf_fetched2 == 32'd0 && perf_bubbles2 == 32'd0, "perf_reset",
            {perf_fetched2, perf_bubbles2}, {32'd0, 32'd0});
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
